// File: rtl/toggle_rx_pkg.sv
// ============================================================================
// Module   : toggle_rx_pkg
// Brief    : Shared types, widths and helpers for the toggle receive monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package toggle_rx_pkg;

    localparam int PERIOD_W         = 16;
    localparam int MCNT_W           = 4;
    localparam int DIFF_W           = PERIOD_W + 1;
    localparam int CLK_FREQ         = 25000000;
    localparam int TICK_DIV_DEFAULT = CLK_FREQ / 1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Signed 17-bit distance so counts below the expected value compare correctly.
    function automatic logic in_tol(input logic [PERIOD_W-1:0] cnt,
                                    input int                  exp_ticks,
                                    input int                  tol_ticks);
        logic signed [DIFF_W-1:0] diff;
        logic signed [DIFF_W-1:0] mag;
        diff = $signed({1'b0, cnt}) - $signed(DIFF_W'(exp_ticks));
        mag  = diff[DIFF_W-1] ? -diff : diff;
        return (mag <= $signed(DIFF_W'(tol_ticks)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/toggle_rx_monitor_if.sv
// ============================================================================
// Module   : toggle_rx_monitor_if
// Brief    : Toggle input and measurement/status bundle of the receive monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface toggle_rx_monitor_if;
    import toggle_rx_pkg::*;

    logic                rx_in;
    logic                rx_level;
    logic                edge_pulse;
    logic [PERIOD_W-1:0] period_ticks;
    logic                period_valid;
    logic                locked;
    logic                timeout;
    logic                led1;
    logic                led2;

    modport master (
        input  rx_in,
        output rx_level, edge_pulse, period_ticks, period_valid,
               locked, timeout, led1, led2
    );

    modport slave (
        output rx_in,
        input  rx_level, edge_pulse, period_ticks, period_valid,
               locked, timeout, led1, led2
    );

endinterface

`default_nettype wire

// File: rtl/toggle_rx_sync_filter.sv
// ============================================================================
// Module   : toggle_rx_sync_filter
// Brief    : Input synchronizer, optional glitch filter (TOGGLE_RX_GLITCH_FILTER_EN)
//            and edge detector producing rx_level / edge_pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_rx_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_in_i,
    output logic rx_level_o,
    output logic edge_pulse_o
);

    if (SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_bad_cfg
        $error("toggle_rx_sync_filter: SYNC_STAGES must be >= 2 and DEB_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_w;
    logic                   level_d;
    logic                   level_q;
    logic                   edge_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in_i};
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

`ifdef TOGGLE_RX_GLITCH_FILTER_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [DEB_W-1:0] deb_d;
    logic [DEB_W-1:0] deb_q;

    // Level follows only after the new value has been seen DEB_CYCLES times in a row.
    always_comb begin
        deb_d   = '0;
        level_d = level_q;
        if (sync_w != level_q) begin
            if (deb_q == DEB_W'(DEB_CYCLES)) begin
                level_d = sync_w;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= '0;
        end else begin
            deb_q <= deb_d;
        end
    end
`else
    always_comb begin
        level_d = sync_w;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            edge_q  <= (level_d != level_q);
        end
    end

    assign rx_level_o   = level_q;
    assign edge_pulse_o = edge_q;

endmodule

`default_nettype wire

// File: rtl/toggle_rx_monitor.sv
// ============================================================================
// Module   : toggle_rx_monitor
// Brief    : Half-period measurement and lock detection of a slow toggling input.
//            Glitch filter enabled by TOGGLE_RX_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module toggle_rx_monitor
    import toggle_rx_pkg::*;
#(
    parameter int TICK_DIV       = TICK_DIV_DEFAULT,
    parameter int EXP_HALF_TICKS = 3000,
    parameter int TOL_TICKS      = 100,
    parameter int LOCK_CNT       = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_CYCLES     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    toggle_rx_monitor_if.master  bus
);

    if (LOCK_CNT < 1 || LOCK_CNT > 15 || TICK_DIV < 2) begin : g_bad_cfg
        $error("toggle_rx_monitor: LOCK_CNT must be 1..15 and TICK_DIV >= 2");
    end

    localparam int                  DIV_W       = $clog2(TICK_DIV);
    localparam logic [PERIOD_W-1:0] TIMEOUT_LIM = PERIOD_W'(2 * EXP_HALF_TICKS);
    localparam logic [PERIOD_W-1:0] HP_MAX      = '1;

    logic                rx_level_w;
    logic                edge_w;
    logic                tick_w;
    logic                in_tol_w;
    logic [MCNT_W:0]     mcnt_inc_w;

    logic [DIV_W-1:0]    div_d,  div_q;
    logic [PERIOD_W-1:0] hp_d,   hp_q;
    state_t              state_q;
    logic [MCNT_W-1:0]   mcnt_q;
    logic [PERIOD_W-1:0] period_q;
    logic                pvalid_q;
    logic                locked_q;
    logic                timeout_q;

    toggle_rx_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_sync_filter (
        .clk          (clk),
        .rst          (rst),
        .rx_in_i      (bus.rx_in),
        .rx_level_o   (rx_level_w),
        .edge_pulse_o (edge_w)
    );

    assign tick_w     = (div_q == DIV_W'(TICK_DIV - 1));
    assign in_tol_w   = in_tol(hp_q, EXP_HALF_TICKS, TOL_TICKS);
    assign mcnt_inc_w = {1'b0, mcnt_q} + 1'b1;

    // An edge clears the count even when a tick lands on the same cycle.
    always_comb begin
        div_d = tick_w ? '0 : div_q + 1'b1;
        hp_d  = hp_q;
        if (edge_w) begin
            hp_d = '0;
        end else if (tick_w && hp_q != HP_MAX) begin
            hp_d = hp_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            hp_q  <= '0;
        end else begin
            div_q <= div_d;
            hp_q  <= hp_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcnt_q    <= '0;
            period_q  <= '0;
            pvalid_q  <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            pvalid_q <= 1'b0;
            if (edge_w) begin
                timeout_q <= 1'b0;
                if (state_q == IDLE) begin
                    state_q <= MEASURE;
                    mcnt_q  <= '0;
                end else begin
                    period_q <= hp_q;
                    pvalid_q <= 1'b1;
                    if (state_q == MEASURE) begin
                        if (!in_tol_w) begin
                            mcnt_q <= '0;
                        end else begin
                            mcnt_q <= mcnt_inc_w[MCNT_W-1:0];
                            if (mcnt_inc_w == (MCNT_W+1)'(LOCK_CNT)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end
                    end else if (!in_tol_w) begin
                        state_q  <= MEASURE;
                        mcnt_q   <= '0;
                        locked_q <= 1'b0;
                    end
                end
            end else if (state_q != IDLE && hp_q > TIMEOUT_LIM) begin
                // Line went quiet: drop lock and treat the next edge as a fresh start.
                state_q   <= IDLE;
                mcnt_q    <= '0;
                locked_q  <= 1'b0;
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.rx_level     = rx_level_w;
    assign bus.edge_pulse   = edge_w;
    assign bus.period_ticks = period_q;
    assign bus.period_valid = pvalid_q;
    assign bus.locked       = locked_q;
    assign bus.timeout      = timeout_q;
    assign bus.led1         = locked_q;
    assign bus.led2         = rx_level_w;

endmodule

`default_nettype wire

// File: tb/tb_toggle_rx_monitor.sv
// ============================================================================
// Module   : tb_toggle_rx_monitor
// Brief    : Directed, table-driven bench for toggle_rx_monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_toggle_rx_monitor;

    localparam int SYNC = 2;
    localparam int DEB  = 16;
`ifdef TOGGLE_RX_GLITCH_FILTER_EN
    localparam int LAT  = SYNC + DEB + 1;
`else
    localparam int LAT  = SYNC + 1;
`endif
    // Flip phase placing every edge five cycles away from a tick.
    localparam int BASE = (1000 + 5 - (LAT + 1)) % 10;

    typedef struct {
        int gap;
        bit measured;
        int exp_ticks;
        bit exp_locked;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   k_last;
    logic lvl;
    int   total;
    int   bad;
    int   p;
    vec_t tab_a[15];
    vec_t tab_b[3];

    toggle_rx_monitor_if bus();

    toggle_rx_monitor #(
        .TICK_DIV       (10),
        .EXP_HALF_TICKS (30),
        .TOL_TICKS      (2),
        .LOCK_CNT       (3),
        .SYNC_STAGES    (SYNC),
        .DEB_CYCLES     (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_level"},     bus.rx_level,     0);
        chk({tag, "_edge_pulse"},   bus.edge_pulse,   0);
        chk({tag, "_period_ticks"}, bus.period_ticks, 0);
        chk({tag, "_period_valid"}, bus.period_valid, 0);
        chk({tag, "_locked"},       bus.locked,       0);
        chk({tag, "_timeout"},      bus.timeout,      0);
        chk({tag, "_led1"},         bus.led1,         0);
        chk({tag, "_led2"},         bus.led2,         0);
    endtask

    // Flip rx_in gap cycles after the previous flip and observe the resulting edge.
    task automatic run_vec(input string tag, input vec_t v);
        int ep_at, pv_at, ep_n, pv_n, cap, lk;
        wait_cyc(k_last + v.gap);
        k_last    = k_last + v.gap;
        lvl       = ~lvl;
        bus.rx_in = lvl;
        ep_at = -1; pv_at = -1; ep_n = 0; pv_n = 0; cap = -1; lk = -1;
        for (int c = 1; c <= LAT + 6; c++) begin
            @(posedge clk);
            #1;
            if (bus.edge_pulse) begin
                ep_n++;
                if (ep_at < 0) ep_at = c;
            end
            if (bus.period_valid) begin
                pv_n++;
                if (pv_at < 0) begin
                    pv_at = c;
                    cap   = int'(bus.period_ticks);
                    lk    = int'(bus.locked);
                end
            end
        end
        chk({tag, "_edge_latency"}, ep_at, LAT);
        chk({tag, "_edge_count"},   ep_n,  1);
        if (v.measured) begin
            chk({tag, "_valid_latency"}, pv_at, LAT + 1);
            chk({tag, "_valid_count"},   pv_n,  1);
            chk({tag, "_period_ticks"},  cap,   v.exp_ticks);
            chk({tag, "_locked"},        lk,    int'(v.exp_locked));
        end else begin
            chk({tag, "_no_valid"}, pv_n, 0);
        end
        chk({tag, "_led1"}, bus.led1, int'(v.exp_locked));
        chk({tag, "_led2"}, bus.led2, int'(lvl));
    endtask

    initial begin
        int ep_n, pv_n, ep_at;
        total = 0;
        bad   = 0;

        tab_a[0]  = '{BASE, 1'b0,  0, 1'b0};
        tab_a[1]  = '{300,  1'b1, 30, 1'b0};
        tab_a[2]  = '{300,  1'b1, 30, 1'b0};
        tab_a[3]  = '{300,  1'b1, 30, 1'b1};
        tab_a[4]  = '{320,  1'b1, 32, 1'b1};
        tab_a[5]  = '{320,  1'b1, 32, 1'b1};
        tab_a[6]  = '{280,  1'b1, 28, 1'b1};
        tab_a[7]  = '{340,  1'b1, 34, 1'b0};
        tab_a[8]  = '{300,  1'b1, 30, 1'b0};
        tab_a[9]  = '{300,  1'b1, 30, 1'b0};
        tab_a[10] = '{300,  1'b1, 30, 1'b1};
        tab_a[11] = '{270,  1'b1, 27, 1'b0};
        tab_a[12] = '{300,  1'b1, 30, 1'b0};
        tab_a[13] = '{300,  1'b1, 30, 1'b0};
        tab_a[14] = '{300,  1'b1, 30, 1'b1};
        // After a timeout restart: second entry lands on a tick cycle.
        tab_b[0]  = '{300,  1'b1, 30, 1'b0};
        tab_b[1]  = '{305,  1'b1, 30, 1'b0};
        tab_b[2]  = '{305,  1'b1, 30, 1'b1};

        rst       = 1'b1;
        lvl       = 1'b0;
        bus.rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst    = 1'b0;
        k_last = 0;

        for (int i = 0; i < 15; i++) begin
            run_vec($sformatf("vecA%0d", i), tab_a[i]);
        end

        // Hold the line after lock: timeout fires once hp_cnt exceeds 60.
        p = k_last + LAT + 1;
        wait_cyc(p + 605);
        chk("pre_timeout_flag",   bus.timeout, 0);
        chk("pre_timeout_locked", bus.locked,  1);
        wait_cyc(p + 606);
        chk("timeout_flag",   bus.timeout, 1);
        chk("timeout_locked", bus.locked,  0);
        chk("timeout_led1",   bus.led1,    0);
        wait_cyc(k_last + 690);
        chk("timeout_hold", bus.timeout, 1);
        run_vec("restart", '{700, 1'b0, 0, 1'b0});
        chk("timeout_cleared", bus.timeout, 0);

        for (int i = 0; i < 3; i++) begin
            run_vec($sformatf("vecB%0d", i), tab_b[i]);
        end

        // Asynchronous reset in the middle of a cycle, while locked.
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        k_last = 0;
        ep_n = 0;
        pv_n = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (bus.edge_pulse)   ep_n++;
            if (bus.period_valid) pv_n++;
        end
        chk("post_reset_resync_edges", ep_n, 1);
        chk("post_reset_no_valid",     pv_n, 0);
        run_vec("post_reset_second", '{BASE + 300, 1'b1, 30, 1'b0});

`ifdef TOGGLE_RX_GLITCH_FILTER_EN
        repeat (5) @(posedge clk);
        #1;
        bus.rx_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.rx_in = 1'b0;
        ep_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.edge_pulse) ep_n++;
        end
        chk("glitch_ignored", ep_n, 0);
        bus.rx_in = 1'b1;
        ep_at = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.edge_pulse && ep_at < 0) ep_at = c;
        end
        chk("glitch_hold_latency", ep_at, SYNC + 17);
`else
        ep_at = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/toggle_rx_monitor.md
Name: toggle_rx_monitor

Overview:
- Receive-side counterpart of the board's slow square-wave toggler: samples an asynchronous toggling input (optical/comparator return of the backscatter tag's modulated line) and measures each half-period.
- Flags lock when half-periods match the expected toggle interval within tolerance.
- Drives status LEDs and exposes the measured interval to downstream logic.

Parameters:
- TICK_DIV, 25000, clk cycles per measurement tick (1 ms at 25 MHz).
- EXP_HALF_TICKS, 3000, expected half-period in ticks.
- TOL_TICKS, 100, allowed absolute deviation from EXP_HALF_TICKS, inclusive.
- LOCK_CNT, 3, consecutive in-tolerance half-periods needed to lock; range 1..15.
- SYNC_STAGES, 2, synchronizer depth; minimum 2.
- DEB_CYCLES, 16, input-stable cycles for the glitch filter; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx_in  in  1  asynchronous toggling input.
- rx_level  out  1  synchronized (and filtered) input level.
- edge_pulse  out  1  one-cycle pulse on any accepted edge of rx_level.
- period_ticks  out  16  last measured half-period in ticks; saturates at 16'hFFFF.
- period_valid  out  1  one-cycle pulse when period_ticks updates.
- locked  out  1  lock status.
- timeout  out  1  level flag: no edge for more than 2*EXP_HALF_TICKS ticks.
- led1  out  1  equals locked.
- led2  out  1  equals rx_level.

Behaviour:
- Reset is asynchronous and active-high. All outputs, counters, synchronizer and filter registers, and the FSM state clear to 0 or IDLE.
  - rx_level resets to 0.
  - The first accepted edge after reset is never measured. It only starts the count.
- Synchronizer:
  - rx_in passes through SYNC_STAGES flops.
  - An edge is accepted when the filtered level differs from the previous rx_level.
  - edge_pulse asserts in the same cycle that rx_level changes.
  - Latency from rx_in to rx_level is SYNC_STAGES+1 cycles without the filter.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 and emits a one-cycle tick on wrap.
  - It is free-running and is not restarted by edges. Measurement resolution is ±1 tick.
- Half-period counter (hp_cnt, 16 bit):
  - Increments on each tick and saturates at 16'hFFFF.
  - On an accepted edge, outside IDLE: period_ticks <= hp_cnt, period_valid pulses one cycle later, and hp_cnt clears.
  - If a tick and an edge occur in the same cycle, the edge wins: hp_cnt clears and that tick is not added to the captured value.
- In-tolerance test: |hp_cnt - EXP_HALF_TICKS| <= TOL_TICKS, computed 17-bit signed.
- FSM with match counter mcnt (4 bit):
  - IDLE: first edge -> MEASURE with mcnt=0.
  - MEASURE, on edge:
    - In tolerance: mcnt increments. When mcnt+1 == LOCK_CNT, go to LOCKED and assert locked.
    - Out of tolerance: mcnt=0 and stay in MEASURE.
  - LOCKED, on edge: an out-of-tolerance edge goes to MEASURE with mcnt=0 and deasserts locked in the next cycle.
  - Any state other than IDLE, when hp_cnt exceeds 2*EXP_HALF_TICKS:
    - timeout asserts, locked clears, the FSM returns to IDLE and mcnt clears.
    - timeout stays high until the next accepted edge and clears in that edge's cycle.
    - That edge is treated as the first edge and is not measured.
- Reset mid-measurement discards all state; there is no partial-period capture.

Optional Feature:
- Macro: TOGGLE_RX_GLITCH_FILTER_EN.
- Defined:
  - The synchronized input must hold a new value for DEB_CYCLES consecutive clk cycles before rx_level follows.
  - Shorter pulses are ignored entirely: no edge, no count effect.
  - Latency becomes SYNC_STAGES+DEB_CYCLES+1 cycles.
- Undefined:
  - The synchronizer output drives rx_level directly.
  - The DEB_CYCLES parameter is unused.

Decomposition:
- Shared package toggle_rx_pkg holds:
  - FSM state typedef {IDLE, MEASURE, LOCKED}.
  - PERIOD_W=16 and MCNT_W=4.
  - Default CLK_FREQ=25000000 and the default TICK_DIV.
- One sub-module, toggle_rx_sync_filter, contains the synchronizer, the optional glitch filter and edge detection. It outputs rx_level and edge_pulse.
- The prescaler, counter and FSM stay in the top.

Test Plan:
Simulation parameters are TICK_DIV=10, EXP_HALF_TICKS=30, TOL_TICKS=2, LOCK_CNT=3.
- Reset: assert rst mid-count -> all outputs 0 immediately, no period_valid after release until two edges.
- Nominal: toggle rx_in every 300 cycles -> period_ticks=30 (±1) on each period_valid; locked rises on the 3rd measured edge; led1=1.
- Tolerance edges:
  - Half-periods of 32 ticks -> lock holds.
  - A single 34-tick period -> locked falls and mcnt resets.
  - Three further 30-tick periods -> relock.
- Timeout: hold rx_in static after lock -> timeout=1 and locked=0 once hp_cnt>60; next edge clears timeout with no period_valid.
- Tick/edge collision: place an edge on the tick cycle -> captured value excludes that tick and hp_cnt restarts at 0.
- Glitch, with TOGGLE_RX_GLITCH_FILTER_EN and DEB_CYCLES=16:
  - 10-cycle pulse on rx_in -> no edge_pulse.
  - 20-cycle hold -> edge_pulse at SYNC_STAGES+17 cycles.
